// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: parametrised reset controller.
// Synchronises NUM_SRC asynchronous reset requests plus a synchronous software
// request. It holds all domains in reset while any unmasked request is active,
// stretches the reset, and then releases NUM_DOM active-low domain resets one
// at a time. A sticky register records which requests caused a reset.
module rst_seq_ctrl #(
  parameter int NUM_SRC     = 3,
  parameter int SYNC_DP     = 2,
  parameter int STRETCH_CYC = 8,
  parameter int NUM_DOM     = 2,
  parameter int RELEASE_GAP = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] src_mask_i,
  input  logic               sw_rst_i,
  input  logic               cause_clr_i,
  output logic [NUM_DOM-1:0] dom_rst_n_o,
  output logic [NUM_SRC:0]   cause_o,
  output logic               done_o
);

  localparam int CNT_W = $clog2(STRETCH_CYC + 1);
  localparam int GAP_W = $clog2(RELEASE_GAP + 1);
  localparam int IDX_W = $clog2(NUM_DOM + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(RELEASE_GAP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_STRETCH,
    ST_RELEASE,
    ST_RUN
  } state_t;

  // Synchroniser chain: stage 0 samples src_i, and stage SYNC_DP-1 is src_s.
  logic [SYNC_DP-1:0][NUM_SRC-1:0] sync_q;
  logic [NUM_SRC-1:0]              src_s;
  logic [NUM_SRC-1:0]              src_act;
  logic                            req;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gcnt_q, gcnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_q, dom_d;
  logic               done_q, done_d;
  logic [NUM_SRC:0]   cause_q;
  logic [NUM_SRC:0]   cause_set;

  // Shift every source bit through the synchroniser flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DP-2:0], src_i};
    end
  end

  assign src_s   = sync_q[SYNC_DP-1];
  assign src_act = src_s & ~src_mask_i;
  // sw_rst_i is already synchronous to clk, so it bypasses the synchroniser.
  assign req     = (|src_act) | sw_rst_i;

  assign cause_set = {sw_rst_i, src_act};

  // Sticky cause bits. A bit that is being set survives a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cause_q <= '0;
    end else if (cause_clr_i) begin
      cause_q <= cause_set;
    end else begin
      cause_q <= cause_q | cause_set;
    end
  end

  // Sequencer registers: state, counters, and the registered domain outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HOLD;
      cnt_q   <= '0;
      gcnt_q  <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gcnt_q  <= gcnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic. Any request overrides the sequence and re-enters HOLD.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gcnt_d  = gcnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    done_d  = done_q;

    if (req) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      gcnt_d  = '0;
      idx_d   = '0;
      dom_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          state_d = ST_STRETCH;
          cnt_d   = '0;
        end

        ST_STRETCH: begin
          if (cnt_q == CNT_LAST) begin
            dom_d[0] = 1'b1;
            cnt_d    = '0;
            gcnt_d   = '0;
            idx_d    = '0;
            if (NUM_DOM == 1) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (gcnt_q == GAP_LAST) begin
            idx_d  = idx_q + 1'b1;
            dom_d  = dom_q | (NUM_DOM'(1) << idx_d);
            gcnt_d = '0;
            if (idx_d == IDX_LAST) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end
          end else begin
            gcnt_d = gcnt_q + 1'b1;
          end
        end

        ST_RUN: begin
          state_d = ST_RUN;
        end

        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign dom_rst_n_o = dom_q;
  assign done_o      = done_q;
  assign cause_o     = cause_q;

endmodule
